// File: rtl/exmem_pipe.sv
// EX/MEM pipeline register with configurable depth, per-stage valid, stall and flush.
// Optional EXMEM_FWD_EN adds EX-operand forwarding comparators over the stage registers.
module exmem_pipe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_aluout_i,
  input  logic [DATA_W-1:0] in_wdata_i,
  input  logic [ADDR_W-1:0] in_rd_i,
  input  logic [ADDR_W-1:0] in_branch_addr_i,
  input  logic [ADDR_W-1:0] in_jump_addr_i,
  input  logic [3:0]        in_flags_i,
  input  logic [6:0]        in_ctrl_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_aluout_o,
  output logic [DATA_W-1:0] out_wdata_o,
  output logic [ADDR_W-1:0] out_rd_o,
  output logic [ADDR_W-1:0] out_branch_addr_o,
  output logic [ADDR_W-1:0] out_jump_addr_o,
  output logic [3:0]        out_flags_o,
  output logic [6:0]        out_ctrl_o,
`ifdef EXMEM_FWD_EN
  input  logic [ADDR_W-1:0] fwd_src_a_i,
  input  logic [ADDR_W-1:0] fwd_src_b_i,
  output logic              fwd_a_hit_o,
  output logic              fwd_b_hit_o,
  output logic [DATA_W-1:0] fwd_a_data_o,
  output logic [DATA_W-1:0] fwd_b_data_o,
`endif
  output logic [2:0]        occupancy_o
);

  if (STAGES == 0 || STAGES > 4) begin : gen_stages_check
    $error("exmem_pipe: STAGES must be in 1..4");
  end

  localparam int unsigned CtrlRegWrite = 1;
  localparam int unsigned CtrlMemtoReg = 0;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] branch_addr;
    logic [ADDR_W-1:0] jump_addr;
    logic [3:0]        flags;
    logic [6:0]        ctrl;
  } stage_t;

  stage_t [STAGES-1:0] stg_q, stg_d;
  stage_t              in_stage;
  logic   [2:0]        occ_q, occ_d;

  always_comb begin
    in_stage.valid       = in_valid_i;
    in_stage.aluout      = in_aluout_i;
    in_stage.wdata       = in_wdata_i;
    in_stage.rd          = in_rd_i;
    in_stage.branch_addr = in_branch_addr_i;
    in_stage.jump_addr   = in_jump_addr_i;
    in_stage.flags       = in_flags_i;
    // Bubbles never carry control, so downstream can trust ctrl without checking valid.
    in_stage.ctrl        = in_valid_i ? in_ctrl_i : 7'b0;
  end

  always_comb begin
    stg_d = stg_q;
    if (flush_i) begin
      stg_d = '0;
    end else if (!stall_i) begin
      stg_d[0] = in_stage;
      for (int k = 1; k < int'(STAGES); k++) begin
        stg_d[k] = stg_q[k-1];
      end
    end
    occ_d = 3'd0;
    for (int k = 0; k < int'(STAGES); k++) begin
      occ_d = occ_d + {2'b00, stg_d[k].valid};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stg_q <= '0;
      occ_q <= 3'd0;
    end else begin
      stg_q <= stg_d;
      occ_q <= occ_d;
    end
  end

  assign out_valid_o       = stg_q[STAGES-1].valid;
  assign out_aluout_o      = stg_q[STAGES-1].aluout;
  assign out_wdata_o       = stg_q[STAGES-1].wdata;
  assign out_rd_o          = stg_q[STAGES-1].rd;
  assign out_branch_addr_o = stg_q[STAGES-1].branch_addr;
  assign out_jump_addr_o   = stg_q[STAGES-1].jump_addr;
  assign out_flags_o       = stg_q[STAGES-1].flags;
  assign out_ctrl_o        = stg_q[STAGES-1].ctrl;
  assign occupancy_o       = occ_q;

`ifdef EXMEM_FWD_EN
  // Scan oldest to youngest so the youngest (lowest index) match wins.
  always_comb begin
    fwd_a_hit_o  = 1'b0;
    fwd_a_data_o = '0;
    fwd_b_hit_o  = 1'b0;
    fwd_b_data_o = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      if (stg_q[k].valid && stg_q[k].ctrl[CtrlRegWrite] && !stg_q[k].ctrl[CtrlMemtoReg]) begin
        if (stg_q[k].rd == fwd_src_a_i) begin
          fwd_a_hit_o  = 1'b1;
          fwd_a_data_o = stg_q[k].aluout;
        end
        if (stg_q[k].rd == fwd_src_b_i) begin
          fwd_b_hit_o  = 1'b1;
          fwd_b_data_o = stg_q[k].aluout;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_exmem_pipe.sv
// Scoreboard bench for exmem_pipe: stimulus pushes expected instructions, a negedge
// monitor pops and checks them; forwarding checks run when EXMEM_FWD_EN is defined.
module tb_exmem_pipe;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 32;
`ifdef EXMEM_FWD_EN
  localparam int unsigned S = 3;
`else
  localparam int unsigned S = 2;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_aluout = '0;
  logic [DW-1:0] in_wdata = '0;
  logic [AW-1:0] in_rd = '0;
  logic [AW-1:0] in_ba = '0;
  logic [AW-1:0] in_ja = '0;
  logic [3:0]    in_flags = '0;
  logic [6:0]    in_ctrl = '0;
  logic          out_valid;
  logic [DW-1:0] out_aluout, out_wdata;
  logic [AW-1:0] out_rd, out_ba, out_ja;
  logic [3:0]    out_flags;
  logic [6:0]    out_ctrl;
  logic [2:0]    occupancy;
`ifdef EXMEM_FWD_EN
  logic [AW-1:0] fwd_src_a = '0;
  logic [AW-1:0] fwd_src_b = '0;
  logic          fwd_a_hit, fwd_b_hit;
  logic [DW-1:0] fwd_a_data, fwd_b_data;
`endif

  always #5 clk = ~clk;

  exmem_pipe #(.DATA_W(DW), .ADDR_W(AW), .STAGES(S)) u_dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .stall_i           (stall),
    .flush_i           (flush),
    .in_valid_i        (in_valid),
    .in_aluout_i       (in_aluout),
    .in_wdata_i        (in_wdata),
    .in_rd_i           (in_rd),
    .in_branch_addr_i  (in_ba),
    .in_jump_addr_i    (in_ja),
    .in_flags_i        (in_flags),
    .in_ctrl_i         (in_ctrl),
    .out_valid_o       (out_valid),
    .out_aluout_o      (out_aluout),
    .out_wdata_o       (out_wdata),
    .out_rd_o          (out_rd),
    .out_branch_addr_o (out_ba),
    .out_jump_addr_o   (out_ja),
    .out_flags_o       (out_flags),
    .out_ctrl_o        (out_ctrl),
`ifdef EXMEM_FWD_EN
    .fwd_src_a_i       (fwd_src_a),
    .fwd_src_b_i       (fwd_src_b),
    .fwd_a_hit_o       (fwd_a_hit),
    .fwd_b_hit_o       (fwd_b_hit),
    .fwd_a_data_o      (fwd_a_data),
    .fwd_b_data_o      (fwd_b_data),
`endif
    .occupancy_o       (occupancy)
  );

  typedef struct {
    logic [DW-1:0] alu;
    logic [DW-1:0] wd;
    logic [AW-1:0] rd;
    logic [AW-1:0] ba;
    logic [AW-1:0] ja;
    logic [3:0]    fl;
    logic [6:0]    ct;
    int            due;
  } exp_t;

  typedef enum int {KNone, KReset, KFlush, KStall, KAdv} kind_e;

  exp_t       sbq[$];
  kind_e      last_kind = KNone;
  int         adv_cnt = 0;
  logic [S-1:0] vm = '0;
  int         checks = 0;
  int         fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model is updated right after the edge it describes.
  task automatic step(input logic rst, input logic st, input logic fl, input logic v,
                      input logic [7:0] alu, input logic [31:0] rd, input logic [3:0] flg,
                      input logic [6:0] ct);
    exp_t e;
    @(negedge clk);
    rst_n     = rst;
    stall     = st;
    flush     = fl;
    in_valid  = v;
    in_aluout = alu;
    in_wdata  = ~alu;
    in_rd     = rd;
    in_ba     = 32'hB000_0000 | rd;
    in_ja     = 32'hC000_0000 | {24'h0, alu};
    in_flags  = flg;
    in_ctrl   = ct;
    @(posedge clk);
    if (!rst) begin
      sbq.delete();
      vm = '0;
      last_kind = KReset;
    end else if (fl) begin
      sbq.delete();
      vm = '0;
      last_kind = KFlush;
    end else if (st) begin
      last_kind = KStall;
    end else begin
      adv_cnt++;
      vm = (vm << 1) | S'(v);
      if (v) begin
        e.alu = alu; e.wd = ~alu; e.rd = rd;
        e.ba = 32'hB000_0000 | rd; e.ja = 32'hC000_0000 | {24'h0, alu};
        e.fl = flg; e.ct = ct; e.due = adv_cnt + int'(S) - 1;
        sbq.push_back(e);
      end
      last_kind = KAdv;
    end
  endtask

  // Monitor: compares what the DUT presents against the model after every edge.
  logic          p_v;
  logic [DW-1:0] p_alu, p_wd;
  logic [AW-1:0] p_rd, p_ba, p_ja;
  logic [3:0]    p_fl;
  logic [6:0]    p_ct;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (last_kind != KNone) begin
        case (last_kind)
          KReset, KFlush: begin
            chk("clr_valid", 32'(out_valid), 32'h0);
            chk("clr_alu", 32'(out_aluout), 32'h0);
            chk("clr_wdata", 32'(out_wdata), 32'h0);
            chk("clr_rd", out_rd, 32'h0);
            chk("clr_ba", out_ba, 32'h0);
            chk("clr_ja", out_ja, 32'h0);
            chk("clr_flags", 32'(out_flags), 32'h0);
            chk("clr_ctrl", 32'(out_ctrl), 32'h0);
          end
          KStall: begin
            chk("hold_valid", 32'(out_valid), 32'(p_v));
            chk("hold_alu", 32'(out_aluout), 32'(p_alu));
            chk("hold_wdata", 32'(out_wdata), 32'(p_wd));
            chk("hold_rd", out_rd, p_rd);
            chk("hold_ba", out_ba, p_ba);
            chk("hold_ja", out_ja, p_ja);
            chk("hold_flags", 32'(out_flags), 32'(p_fl));
            chk("hold_ctrl", 32'(out_ctrl), 32'(p_ct));
          end
          default: begin
            if (sbq.size() > 0 && sbq[0].due == adv_cnt) begin
              e = sbq.pop_front();
              chk("out_valid", 32'(out_valid), 32'h1);
              chk("out_alu", 32'(out_aluout), 32'(e.alu));
              chk("out_wdata", 32'(out_wdata), 32'(e.wd));
              chk("out_rd", out_rd, e.rd);
              chk("out_ba", out_ba, e.ba);
              chk("out_ja", out_ja, e.ja);
              chk("out_flags", 32'(out_flags), 32'(e.fl));
              chk("out_ctrl", 32'(out_ctrl), 32'(e.ct));
            end else begin
              chk("bubble_valid", 32'(out_valid), 32'h0);
              chk("bubble_ctrl", 32'(out_ctrl), 32'h0);
            end
          end
        endcase
        chk("occupancy", 32'(occupancy), 32'($countones(vm)));
        p_v = out_valid; p_alu = out_aluout; p_wd = out_wdata; p_rd = out_rd;
        p_ba = out_ba; p_ja = out_ja; p_fl = out_flags; p_ct = out_ctrl;
      end
    end
  end

`ifdef EXMEM_FWD_EN
  task automatic fwd_chk(input logic [31:0] sa, input logic [31:0] sb,
                         input logic ha, input logic [7:0] da,
                         input logic hb, input logic [7:0] db);
    fwd_src_a = sa;
    fwd_src_b = sb;
    #1;
    chk("fwd_a_hit", 32'(fwd_a_hit), 32'(ha));
    chk("fwd_a_data", 32'(fwd_a_data), 32'(da));
    chk("fwd_b_hit", 32'(fwd_b_hit), 32'(hb));
    chk("fwd_b_data", 32'(fwd_b_data), 32'(db));
  endtask
`endif

  initial begin
    // Reset held two cycles with live, nonzero input.
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 32'd3, 4'hF, 7'h7F);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 32'd4, 4'hF, 7'h7F);
    // Release under stall: still empty.
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h66, 32'd6, 4'hF, 7'h7F);

    // Stream with cr-only flags, then a 3-cycle stall mid-stream.
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 32'd1, 4'b0010, 7'h02);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 32'd2, 4'b0010, 7'h02);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 32'd3, 4'b0010, 7'h02);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 8'hEE, 32'd14, 4'hF, 7'h7F);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h44, 32'd4, 4'b1000, 7'h7F);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 32'd5, 4'b0001, 7'h01);
    // Bubble with all control lines set at the input.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h99, 32'd9, 4'hF, 7'h7F);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h66, 32'd6, 4'b0100, 7'h40);
    for (int i = 0; i < int'(S) + 1; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 4'h0, 7'h00);

    // Flush together with stall while the pipe holds full-control instructions.
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h77, 32'd7, 4'b0011, 7'h7F);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h88, 32'd8, 4'b1100, 7'h7F);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h99, 32'd9, 4'hF, 7'h7F);
    for (int i = 0; i < int'(S) + 1; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 4'h0, 7'h00);

`ifdef EXMEM_FWD_EN
    // Oldest to youngest: rd5/BB, rd7/01, rd5/AA, all RegWrite only.
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'hBB, 32'd5, 4'h0, 7'h02);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 32'd7, 4'h0, 7'h02);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'hAA, 32'd5, 4'h0, 7'h02);
    fwd_chk(32'd5, 32'd7, 1'b1, 8'hAA, 1'b1, 8'h01);
    fwd_chk(32'd5, 32'd9, 1'b1, 8'hAA, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 32'd0, 4'h0, 7'h00);
    // Youngest rd5 and the rd7 entry are loads (MemtoReg) and must not forward.
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'hBB, 32'd5, 4'h0, 7'h02);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 32'd7, 4'h0, 7'h03);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'hAA, 32'd5, 4'h0, 7'h03);
    fwd_chk(32'd5, 32'd7, 1'b1, 8'hBB, 1'b0, 8'h00);
    for (int i = 0; i < int'(S) + 1; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0, 4'h0, 7'h00);
`endif

    @(negedge clk);
    #1;
    chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
